// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of pwm_in in clk cycles,
// with a sticky timeout when no rising edge is seen within TIMEOUT cycles.
module pwm_capture #(
  parameter int unsigned TIMEOUT = 32'd4000000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [31:0] d,
  output logic [31:0] t,
  output logic        valid,
  output logic        timeout,
  output logic        level
);

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_cnt_hi, r_cnt_per, r_hi_lat, r_idle_cnt;
  logic [CW-1:0] w_cnt_hi_nxt, w_cnt_per_nxt, w_hi_lat_nxt, w_idle_nxt;
  logic [CW-1:0] w_d_nxt, w_t_nxt;
  logic          w_valid_nxt, w_timeout_nxt;
  logic          w_rise, w_fall;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign level  = r_s2;

  // Next-state and counter logic; enable=0 overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_hi_nxt  = r_cnt_hi;
    w_cnt_per_nxt = r_cnt_per;
    w_hi_lat_nxt  = r_hi_lat;
    w_idle_nxt    = r_idle_cnt;
    w_d_nxt       = d;
    w_t_nxt       = t;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = timeout;
    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_cnt_hi_nxt  = '0;
      w_cnt_per_nxt = '0;
      w_hi_lat_nxt  = '0;
      w_idle_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_hi_nxt  = '0;
          w_cnt_per_nxt = '0;
          if (w_rise) begin
            w_state_nxt   = S_ARMED;
            w_cnt_hi_nxt  = CW'(1);
            w_cnt_per_nxt = CW'(1);
            w_idle_nxt    = '0;
          end else if (r_idle_cnt == TMO_M1) begin
            w_timeout_nxt = 1'b1;
            w_idle_nxt    = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + CW'(1);
          end
        end
        S_ARMED, S_MEASURE: begin
          w_idle_nxt = '0;
          if (w_rise) begin
            // A rise on the TIMEOUT cycle still counts as a valid period.
            if (r_state == S_MEASURE) begin
              w_d_nxt       = r_hi_lat;
              w_t_nxt       = r_cnt_per;
              w_valid_nxt   = 1'b1;
              w_timeout_nxt = 1'b0;
            end
            w_state_nxt   = S_MEASURE;
            w_cnt_hi_nxt  = CW'(1);
            w_cnt_per_nxt = CW'(1);
          end else if (r_cnt_per == TMO) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_cnt_hi_nxt  = '0;
            w_cnt_per_nxt = '0;
            w_hi_lat_nxt  = '0;
          end else begin
            w_cnt_per_nxt = r_cnt_per + CW'(1);
            if (r_s2) w_cnt_hi_nxt = r_cnt_hi + CW'(1);
            if (w_fall) w_hi_lat_nxt = r_cnt_hi;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_cnt_hi_nxt  = '0;
          w_cnt_per_nxt = '0;
          w_hi_lat_nxt  = '0;
          w_idle_nxt    = '0;
        end
      endcase
    end
  end

  // Synchronizer, edge register, state and result registers.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt_hi   <= '0;
      r_cnt_per  <= '0;
      r_hi_lat   <= '0;
      r_idle_cnt <= '0;
      d          <= '0;
      t          <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      r_s1       <= pwm_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_state    <= w_state_nxt;
      r_cnt_hi   <= w_cnt_hi_nxt;
      r_cnt_per  <= w_cnt_per_nxt;
      r_hi_lat   <= w_hi_lat_nxt;
      r_idle_cnt <= w_idle_nxt;
      d          <= w_d_nxt;
      t          <= w_t_nxt;
      valid      <= w_valid_nxt;
      timeout    <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected d/t/cycle per
// reported rise, a negedge monitor pops and checks on every valid pulse.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        res;
  logic        enable;
  logic        pwm_in;
  logic [31:0] d, t;
  logic        valid, timeout, level;

  typedef struct {
    logic [31:0] d;
    logic [31:0] t;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  pwm_capture #(.TIMEOUT(1000)) dut (
    .clk(clk), .res(res), .enable(enable), .pwm_in(pwm_in),
    .d(d), .t(t), .valid(valid), .timeout(timeout), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp_v, cyc_cnt);
    end
  endtask

  // Monitor: every valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got d=%0d t=%0d expected no valid (cycle %0d)", d, t, cyc_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_d", d, e.d);
        chk("valid_t", t, e.t);
        chk("valid_cycle", cyc_cnt, e.cyc);
        chk("valid_clears_timeout", 32'(timeout), 32'd0);
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int unsigned h, input int unsigned p, input bit ev,
                       input logic [31:0] ed, input logic [31:0] et);
    exp_t e;
    if (ev) begin
      e.d = ed; e.t = et; e.cyc = cyc_cnt + 3;
      q.push_back(e);
    end
    pwm_in = 1'b1;
    cyc(h);
    pwm_in = 1'b0;
    cyc(p - h);
  endtask

  initial begin
    exp_t e;
    res = 1'b0; enable = 1'b1; pwm_in = 1'b0;
    cyc(3);
    chk("rst_d", d, 32'd0);
    chk("rst_t", t, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    res = 1'b1;

    // 150/500 stream: first two rises only arm the measurement
    pulse(150, 500, 1'b0, 0, 0);
    pulse(150, 500, 1'b0, 0, 0);
    repeat (3) pulse(150, 500, 1'b1, 32'd150, 32'd500);

    // Duty change: report lags by one period
    pulse(400, 500, 1'b1, 32'd150, 32'd500);
    pulse(400, 500, 1'b1, 32'd400, 32'd500);

    // Hold low after a valid: timeout exactly 1000 cycles after the rise
    e.d = 32'd400; e.t = 32'd500; e.cyc = cyc_cnt + 3;
    q.push_back(e);
    pwm_in = 1'b1;
    cyc(400);
    pwm_in = 1'b0;
    cyc(602);
    chk("timeout_before_1000", 32'(timeout), 32'd0);
    cyc(1);
    chk("timeout_at_1000", 32'(timeout), 32'd1);
    chk("timeout_hold_d", d, 32'd400);
    chk("timeout_hold_t", t, 32'd500);

    // Recover from IDLE with a 300-cycle period
    pulse(150, 300, 1'b0, 0, 0);
    pulse(150, 300, 1'b0, 0, 0);
    chk("timeout_sticky", 32'(timeout), 32'd1);
    pulse(150, 1000, 1'b1, 32'd150, 32'd300);
    // Rise on the cnt_per==1000 cycle wins over timeout
    pulse(150, 300, 1'b1, 32'd150, 32'd1000);
    chk("boundary_1000_no_timeout", 32'(timeout), 32'd0);
    pulse(150, 1001, 1'b1, 32'd150, 32'd300);
    chk("boundary_1001_pre", 32'(timeout), 32'd0);
    pwm_in = 1'b1;
    cyc(2);
    chk("boundary_1001_timeout", 32'(timeout), 32'd1);
    chk("boundary_1001_hold_d", d, 32'd150);
    chk("boundary_1001_hold_t", t, 32'd300);
    cyc(148);
    pwm_in = 1'b0;
    cyc(50);

    // Disabled while a 100/200 waveform runs
    enable = 1'b0;
    repeat (10) pulse(100, 200, 1'b0, 0, 0);
    chk("disabled_hold_d", d, 32'd150);
    chk("disabled_hold_t", t, 32'd300);
    chk("disabled_hold_timeout", 32'(timeout), 32'd1);
    enable = 1'b1;
    pulse(100, 200, 1'b0, 0, 0);
    pulse(100, 200, 1'b0, 0, 0);
    pulse(100, 200, 1'b1, 32'd100, 32'd200);
    pulse(100, 200, 1'b1, 32'd100, 32'd200);

    // Reset pulse between clock edges has no effect
    res = 1'b0;
    #3;
    res = 1'b1;
    cyc(1);
    chk("short_res_d", d, 32'd100);
    chk("short_res_t", t, 32'd200);

    // Reset in MEASURE while pwm_in is high
    e.d = 32'd100; e.t = 32'd201; e.cyc = cyc_cnt + 3;
    q.push_back(e);
    pwm_in = 1'b1;
    cyc(50);
    chk("level_high", 32'(level), 32'd1);
    res = 1'b0;
    cyc(1);
    chk("mid_rst_d", d, 32'd0);
    chk("mid_rst_t", t, 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    pwm_in = 1'b0;
    cyc(3);
    res = 1'b1;
    pulse(100, 200, 1'b0, 0, 0);
    pulse(100, 200, 1'b0, 0, 0);
    pulse(100, 200, 1'b1, 32'd100, 32'd200);
    cyc(10);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
